npu_host_seq: RTL and testbench

- Host-side sequencer that drives the NPU shared 32-bit data bus from the host end.
- Pulls a job (6 config words followed by the load words) from a valid/ready source stream.
- Starts the NPU, replays the configuration and streams the load words with zero bubbles.
- Waits for the NPU ready flag, then reads the output neurons into a valid/ready sink stream.

---
 rtl/npu_host_seq.sv | 186 ++++++++++++++++++
 tb/tb_npu_host_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_host_seq.sv
// Host-side NPU sequencer: pulls a job from a source stream, programs the NPU over
// the shared bus, waits for results and drains the output neurons into a sink stream.
module npu_host_seq #(
  parameter int                   TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [31:0] snk_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  output logic        npu_we,
  output logic        npu_oe,
  input  logic        npu_ready,
  output logic [31:0] bus_out,
  output logic        bus_oe,
  input  logic [31:0] bus_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CALC, S_START, S_CFG, S_LOAD, S_WAIT, S_READ, S_DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT - 1'b1;

  state_t                 state;
  logic [2:0]             idx;
  logic [11:0]            w_acc;
  logic [11:0]            load_cnt;
  logic [TIMEOUT_W-1:0]   tmo_cnt;
  logic [5:0]             out_cnt;
  logic [31:0]            cfg [6];
  logic [1:0]             n_layers;
  logic [5:0]             sz [4];
  logic [11:0]            link_add;

  // Weight count of one link: (inputs + bias) * outputs.
  function automatic logic [11:0] link_w(input logic [5:0] s_in, input logic [5:0] s_out);
    logic [11:0] a;
    logic [11:0] b;
    a = {6'd0, s_in} + 12'd1;
    b = {6'd0, s_out};
    return a * b;
  endfunction

  always_comb begin
    n_layers = cfg[0][1:0];
    sz[0]    = {1'b0, cfg[1][4:0]} + 6'd1;
    sz[1]    = {1'b0, cfg[2][4:0]} + 6'd1;
    sz[2]    = {1'b0, cfg[3][4:0]} + 6'd1;
    sz[3]    = {1'b0, cfg[4][4:0]} + 6'd1;
    link_add = '0;
    case (idx)
      3'd0: link_add = link_w(sz[0], (n_layers == 2'd0) ? sz[3] : sz[1]);
      3'd1: begin
        if (n_layers == 2'd1)      link_add = link_w(sz[1], sz[3]);
        else if (n_layers == 2'd2) link_add = link_w(sz[1], sz[2]);
      end
      3'd2: if (n_layers == 2'd2) link_add = link_w(sz[2], sz[3]);
      default: link_add = '0;
    endcase
  end

  // Job configuration words are plain data and carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && src_valid) cfg[idx] <= src_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      err      <= 1'b0;
      idx      <= '0;
      w_acc    <= '0;
      load_cnt <= '0;
      tmo_cnt  <= '0;
      out_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err   <= 1'b0;
            busy  <= 1'b1;
            idx   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (src_valid) begin
            if (idx == 3'd5) begin
              idx   <= '0;
              w_acc <= '0;
              state <= S_CALC;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_CALC: begin
          w_acc <= w_acc + link_add;
          if (idx == 3'd2) begin
            idx <= '0;
            if (n_layers == 2'd3) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_START;
            end
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_START: state <= S_CFG;
        S_CFG: begin
          if (idx == 3'd5) begin
            idx      <= '0;
            load_cnt <= '0;
            state    <= S_LOAD;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_LOAD: begin
          // Any bubble here corrupts the NPU load, so the job is abandoned.
          if (!src_valid) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (load_cnt == w_acc - 12'd1) begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end else begin
            load_cnt <= load_cnt + 12'd1;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (npu_ready) begin
            out_cnt <= '0;
            state   <= S_READ;
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_READ: begin
          if (snk_ready) begin
            if (out_cnt == {1'b0, cfg[4][4:0]}) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              out_cnt <= out_cnt + 6'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_out = '0;
    if (state == S_LOAD)     bus_out = src_data;
    else if (state == S_CFG) bus_out = cfg[idx];
  end

  assign src_ready = (state == S_FETCH) || (state == S_LOAD);
  assign bus_oe    = (state == S_CFG) || (state == S_LOAD);
  assign npu_we    = (state == S_START);
  assign npu_oe    = (state == S_READ) && snk_ready;
  assign snk_valid = (state == S_READ) && snk_ready;
  assign snk_data  = (state == S_READ) ? bus_in : 32'd0;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_npu_host_seq.sv
// Bench for npu_host_seq: drives whole jobs and checks bus, handshake and status
// timing against a job-level model of weight count and output count.
module tb_npu_host_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_data;
  logic        src_valid;
  logic        snk_ready;
  logic        npu_ready;
  logic [31:0] bus_in;

  logic        busy, done, err, src_ready, snk_valid, npu_we, npu_oe, bus_oe;
  logic [31:0] snk_data, bus_out;
  logic        t_busy, t_done, t_err, t_src_ready, t_snk_valid, t_npu_we, t_npu_oe, t_bus_oe;
  logic [31:0] t_snk_data, t_bus_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] cfg_m [6];

  always #5 clk = ~clk;

  npu_host_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .npu_we(npu_we), .npu_oe(npu_oe), .npu_ready(npu_ready),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  npu_host_seq #(.TIMEOUT_W(16), .TIMEOUT(16'd16)) dut_t (
    .clk(clk), .rst(rst), .start(start), .busy(t_busy), .done(t_done), .err(t_err),
    .src_data(src_data), .src_valid(src_valid), .src_ready(t_src_ready),
    .snk_data(t_snk_data), .snk_valid(t_snk_valid), .snk_ready(snk_ready),
    .npu_we(t_npu_we), .npu_oe(t_npu_oe), .npu_ready(npu_ready),
    .bus_out(t_bus_out), .bus_oe(t_bus_oe), .bus_in(bus_in)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Weight count from the layer chain implied by the job header.
  function automatic int model_w();
    int chain[$];
    int w;
    int l;
    w = 0;
    l = int'(cfg_m[0][1:0]);
    chain.push_back(int'(cfg_m[1][4:0]) + 1);
    if (l >= 1) chain.push_back(int'(cfg_m[2][4:0]) + 1);
    if (l >= 2) chain.push_back(int'(cfg_m[3][4:0]) + 1);
    chain.push_back(int'(cfg_m[4][4:0]) + 1);
    for (int i = 0; i + 1 < chain.size(); i++) w += (chain[i] + 1) * chain[i + 1];
    return w;
  endfunction

  // rdy_delay < 0: never raise npu_ready and watch the short-timeout instance.
  task automatic run_job(input string tag, input int rdy_delay, input int underrun_at,
                         input int abort_at, input bit bp);
    int w, ns3, k, got, guard;
    bit tgl;
    logic [31:0] ld [$];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    w   = model_w();
    ns3 = int'(cfg_m[4][4:0]) + 1;
    for (int i = 0; i < w; i++) ld.push_back($urandom);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0; guard = 0;
    while (k < 6 && guard < 100) begin
      src_valid = ($urandom_range(0, 3) != 0);
      src_data  = src_valid ? cfg_m[k] : $urandom;
      #1;
      n_tests++;
      if ({busy, err, src_ready, bus_oe, npu_we} !== 5'b10100) begin
        n_fail++;
        $display("FAIL %s fetch: busy,err,src_ready,bus_oe,npu_we=%b want 10100", tag, {busy, err, src_ready, bus_oe, npu_we});
      end
      step();
      if (src_valid) k++;
      guard++;
    end
    src_valid = 1'b1;
    src_data  = ld[0];
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({busy, src_ready, bus_oe, npu_we} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s calc%0d: busy,src_ready,bus_oe,npu_we=%b want 1000", tag, c, {busy, src_ready, bus_oe, npu_we});
      end
      step();
    end
    if (cfg_m[0][1:0] == 2'd3) begin
      src_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        #1;
        n_tests++;
        if ({busy, err, npu_we, bus_oe} !== 4'b0100) begin
          n_fail++;
          $display("FAIL %s bad_layers%0d: busy,err,npu_we,bus_oe=%b want 0100", tag, c, {busy, err, npu_we, bus_oe});
        end
        step();
      end
      return;
    end
    #1;
    n_tests++;
    if ({npu_we, bus_oe, src_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s start: npu_we,bus_oe,src_ready=%b want 100", tag, {npu_we, bus_oe, src_ready});
    end
    step();
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++;
      if ({bus_oe, npu_we, src_ready} !== 3'b100 || bus_out !== cfg_m[c]) begin
        n_fail++;
        $display("FAIL %s cfg%0d: oe,we,rdy=%b bus_out=%h want 100 %h", tag, c, {bus_oe, npu_we, src_ready}, bus_out, cfg_m[c]);
      end
      step();
    end
    for (int i = 0; i < w; i++) begin
      src_valid = (i != underrun_at);
      src_data  = ld[i];
      if (i == abort_at) begin
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, err, src_ready, snk_valid, npu_we, npu_oe, bus_oe, snk_data, bus_out} !== 72'd0) begin
          n_fail++;
          $display("FAIL %s abort: flags=%b snk_data=%h bus_out=%h want all 0", tag, {busy, done, err, src_ready, snk_valid, npu_we, npu_oe, bus_oe}, snk_data, bus_out);
        end
        step();
        rst = 1'b1;
        src_valid = 1'b0;
        step();
        return;
      end
      #1;
      n_tests++;
      if ({bus_oe, src_ready, npu_oe, npu_we} !== 4'b1100 || bus_out !== ld[i]) begin
        n_fail++;
        $display("FAIL %s load%0d: oe,rdy,npu_oe,we=%b bus_out=%h want 1100 %h", tag, i, {bus_oe, src_ready, npu_oe, npu_we}, bus_out, ld[i]);
      end
      step();
      if (i == underrun_at) begin
        src_valid = 1'b0;
        #1;
        n_tests++;
        if ({err, busy, bus_oe, done, src_ready} !== 5'b10000) begin
          n_fail++;
          $display("FAIL %s underrun: err,busy,bus_oe,done,src_ready=%b want 10000", tag, {err, busy, bus_oe, done, src_ready});
        end
        step();
        #1;
        n_tests++;
        if ({done, busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s underrun_nodone: done,busy=%b want 00", tag, {done, busy});
        end
        step();
        return;
      end
    end
    src_valid = 1'b0;
    npu_ready = 1'b0;
    if (rdy_delay < 0) begin
      for (int j = 0; j < 16; j++) begin
        #1;
        n_tests++;
        if ({t_err, t_busy, t_bus_oe} !== 3'b010) begin
          n_fail++;
          $display("FAIL %s wait%0d: err,busy,bus_oe=%b want 010", tag, j, {t_err, t_busy, t_bus_oe});
        end
        step();
      end
      #1;
      n_tests++;
      if ({t_err, t_busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s timeout: err,busy=%b want 10", tag, {t_err, t_busy});
      end
      step();
      return;
    end
    for (int j = 0; j <= rdy_delay; j++) begin
      npu_ready = (j == rdy_delay);
      #1;
      n_tests++;
      if ({bus_oe, npu_oe, busy, done, err} !== 5'b00100) begin
        n_fail++;
        $display("FAIL %s wait%0d: bus_oe,npu_oe,busy,done,err=%b want 00100", tag, j, {bus_oe, npu_oe, busy, done, err});
      end
      step();
    end
    got = 0; guard = 0; tgl = 1'b1;
    while (got < ns3 && guard < 300) begin
      snk_ready = bp ? tgl : ($urandom_range(0, 3) != 0);
      tgl       = ~tgl;
      bus_in    = $urandom;
      if (snk_ready) exp_q.push_back(bus_in);
      #1;
      n_tests++;
      if ({npu_oe, snk_valid, bus_oe, done, busy} !== {snk_ready, snk_ready, 3'b001}) begin
        n_fail++;
        $display("FAIL %s read: npu_oe,snk_valid,bus_oe,done,busy=%b want %b", tag, {npu_oe, snk_valid, bus_oe, done, busy}, {snk_ready, snk_ready, 3'b001});
      end
      if (snk_valid) got_q.push_back(snk_data);
      step();
      if (snk_ready) got++;
      guard++;
    end
    snk_ready = 1'b0;
    npu_ready = 1'b0;
    n_tests++;
    if (got_q.size() != ns3) begin
      n_fail++;
      $display("FAIL %s out_count: got %0d words want %0d", tag, got_q.size(), ns3);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s out_word%0d: got %h want %h", tag, i, got_q[i], exp_q[i]);
      end
    end
    #1;
    n_tests++;
    if ({done, busy, err, npu_oe} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s done: done,busy,err,npu_oe=%b want 1000", tag, {done, busy, err, npu_oe});
    end
    step();
    #1;
    n_tests++;
    if ({done, busy, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle: done,busy,err=%b want 000", tag, {done, busy, err});
    end
    step();
  endtask

  task automatic set_small();
    cfg_m[0] = 32'd0; cfg_m[1] = 32'd1; cfg_m[2] = $urandom; cfg_m[3] = $urandom;
    cfg_m[4] = 32'd0; cfg_m[5] = 32'd0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0;
    snk_ready = 1'b0; npu_ready = 1'b0; bus_in = '0;
    step();
    step();
    n_tests++;
    if ({busy, done, err, src_ready, snk_valid, npu_we, npu_oe, bus_oe, snk_data, bus_out} !== 72'd0 ||
        {t_busy, t_done, t_err, t_src_ready, t_snk_valid, t_npu_we, t_npu_oe, t_bus_oe, t_snk_data, t_bus_out} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset: flags=%b t_flags=%b want all 0", {busy, done, err, src_ready, snk_valid, npu_we, npu_oe, bus_oe}, {t_busy, t_done, t_err, t_src_ready, t_snk_valid, t_npu_we, t_npu_oe, t_bus_oe});
    end
    rst = 1'b1;
    step();
    n_tests++;
    if ({busy, done, err, src_ready, bus_oe, npu_we} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release: flags=%b want 000000", {busy, done, err, src_ready, bus_oe, npu_we});
    end
  endtask

  task automatic test_small_job();
    set_small();
    run_job("small", 20, -1, -1, 1'b0);
  endtask

  task automatic test_two_layers();
    cfg_m[0] = 32'd2; cfg_m[1] = 32'd3; cfg_m[2] = 32'd7;
    cfg_m[3] = 32'd7; cfg_m[4] = 32'd1; cfg_m[5] = 32'd7;
    run_job("two_layer", 3, -1, -1, 1'b0);
  endtask

  task automatic test_underrun();
    set_small();
    run_job("underrun", 5, 1, -1, 1'b0);
  endtask

  task automatic test_read_backpressure();
    cfg_m[0] = 32'd0; cfg_m[1] = 32'($urandom_range(0, 7)); cfg_m[2] = $urandom;
    cfg_m[3] = $urandom; cfg_m[4] = 32'd3; cfg_m[5] = $urandom;
    run_job("backpressure", 4, -1, -1, 1'b1);
  endtask

  task automatic test_bad_layers();
    for (int i = 1; i < 6; i++) cfg_m[i] = $urandom;
    cfg_m[0] = {$urandom} | 32'd3;
    run_job("bad_layers", 2, -1, -1, 1'b0);
    set_small();
    run_job("err_clear", 2, -1, -1, 1'b0);
  endtask

  task automatic test_timeout();
    pulse_reset();
    set_small();
    run_job("timeout", -1, -1, -1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    n_tests++;
    if ({t_err, t_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_clear: err,busy=%b want 01", {t_err, t_busy});
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_load();
    cfg_m[0] = 32'd2; cfg_m[1] = 32'd3; cfg_m[2] = 32'd7;
    cfg_m[3] = 32'd7; cfg_m[4] = 32'd1; cfg_m[5] = 32'd7;
    run_job("abort", 3, -1, 50, 1'b0);
    set_small();
    run_job("after_reset", 6, -1, -1, 1'b0);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 6; i++) cfg_m[i] = $urandom;
      cfg_m[0][1:0] = 2'($urandom_range(0, 2));
      run_job("random", $urandom_range(0, 12), -1, -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_small_job();
    test_two_layers();
    test_underrun();
    test_read_backpressure();
    test_bad_layers();
    test_timeout();
    test_reset_mid_load();
    test_random_jobs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
